ram_arbiter: RTL and testbench

Sequences the CPU's separate instruction-fetch and data-access request ports onto one single-ported RAM with a fixed, parameterised access latency. It sits between the pipelined datapath (`cpu_ram_if` CPU side) and the RAM. It serialises fetch and load/store traffic, with data given priority. It holds completed results until the stalled pipeline can advance, so a request is never serviced twice.

---
 rtl/ram_arbiter_if.sv | 29 ++
 rtl/ram_arbiter.sv | 113 +++++++++++
 tb/tb_ram_arbiter.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_arbiter_if.sv
// rtl/ram_arbiter_if.sv - CPU fetch/data ports and single-ported RAM bus of ram_arbiter
interface ram_arbiter_if;
  logic        iren;
  logic [31:0] iaddr;
  logic [31:0] iload;
  logic        iwait;
  logic        dren;
  logic [3:0]  dwen;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic [31:0] dload;
  logic        dwait;
  logic [31:0] ram_addr;
  logic        ram_ren;
  logic [3:0]  ram_wen;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  // slave is the arbiter's view; master is the CPU plus RAM environment
  modport slave (
    input  iren, iaddr, dren, dwen, daddr, dstore, ram_rdata,
    output iload, iwait, dload, dwait, ram_addr, ram_ren, ram_wen, ram_wdata
  );

  modport master (
    output iren, iaddr, dren, dwen, daddr, dstore, ram_rdata,
    input  iload, iwait, dload, dwait, ram_addr, ram_ren, ram_wen, ram_wdata
  );
endinterface

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - serialises fetch and data requests onto one fixed-latency RAM port
module ram_arbiter #(
  parameter int LATENCY = 1
) (
  input  logic         clk,
  input  logic         nrst,
  ram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} owner_t;

  localparam logic [3:0] LAST = 4'(LATENCY - 1);

  owner_t      owner, owner_nxt, eff;
  logic [3:0]  cnt, cnt_nxt;
  logic        idone, idone_nxt;
  logic        ddone, ddone_nxt;
  logic [31:0] ihold, ihold_nxt;
  logic [31:0] dhold, dhold_nxt;
  logic        dreq_raw, ireq, dreq, complete, rel;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      owner <= OWN_NONE;
      cnt   <= '0;
      idone <= 1'b0;
      ddone <= 1'b0;
      ihold <= '0;
      dhold <= '0;
    end else begin
      owner <= owner_nxt;
      cnt   <= cnt_nxt;
      idone <= idone_nxt;
      ddone <= ddone_nxt;
      ihold <= ihold_nxt;
      dhold <= dhold_nxt;
    end
  end

  always_comb begin
    dreq_raw = bus.dren | (|bus.dwen);
    ireq     = bus.iren & ~idone;
    dreq     = dreq_raw & ~ddone;

    // Arbitration only happens from idle; data always beats fetch
    eff = owner;
    if (!nrst) begin
      eff = OWN_NONE;
    end else if (owner == OWN_NONE) begin
      if (dreq) begin
        eff = OWN_D;
      end else if (ireq) begin
        eff = OWN_I;
      end
    end
    complete = (eff != OWN_NONE) && (cnt == LAST);

    bus.ram_addr  = '0;
    bus.ram_ren   = 1'b0;
    bus.ram_wen   = '0;
    bus.ram_wdata = '0;
    case (eff)
      OWN_I: begin
        bus.ram_addr = bus.iaddr;
        bus.ram_ren  = 1'b1;
      end
      OWN_D: begin
        bus.ram_addr  = bus.daddr;
        bus.ram_ren   = bus.dren;
        bus.ram_wen   = complete ? bus.dwen : 4'b0000;
        bus.ram_wdata = bus.dstore;
      end
      default: ;
    endcase

    bus.iwait = bus.iren & ~idone & ~(complete && (eff == OWN_I));
    bus.dwait = dreq_raw & ~ddone & ~(complete && (eff == OWN_D));
    bus.iload = !nrst ? 32'h0 : (idone ? ihold : bus.ram_rdata);
    bus.dload = !nrst ? 32'h0 : (ddone ? dhold : bus.ram_rdata);
    rel       = ~bus.iwait & ~bus.dwait;

    owner_nxt = owner;
    cnt_nxt   = cnt;
    idone_nxt = idone;
    ddone_nxt = ddone;
    ihold_nxt = ihold;
    dhold_nxt = dhold;

    if (complete) begin
      cnt_nxt   = '0;
      owner_nxt = OWN_NONE;
    end else if (eff != OWN_NONE) begin
      cnt_nxt   = cnt + 4'd1;
      owner_nxt = eff;
    end

    // A flushed requester still gets its RAM access but no done flag
    if (rel) begin
      idone_nxt = 1'b0;
      ddone_nxt = 1'b0;
    end else if (complete) begin
      if ((eff == OWN_I) && bus.iren) begin
        idone_nxt = 1'b1;
        ihold_nxt = bus.ram_rdata;
      end
      if ((eff == OWN_D) && dreq_raw) begin
        ddone_nxt = 1'b1;
        dhold_nxt = bus.ram_rdata;
      end
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - directed scoreboard bench for ram_arbiter at latencies 1, 2 and 3
module tb_ram_arbiter;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  logic        clk = 1'b0;
  logic        nrst;
  logic        iren;
  logic [31:0] iaddr;
  logic        dren;
  logic [3:0]  dwen;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic [31:0] rdata;

  exp_t        sbq[$];
  int          vectors;
  int          miscompares;
  int unsigned w0;

  always #5 clk = ~clk;

  // Instance g has LATENCY = g+1; all share the same CPU stimulus and RAM read data
  for (genvar g = 0; g < 3; g++) begin : g_dut
    ram_arbiter_if bus ();
    int unsigned   wcnt = 0;
    logic [31:0]   word300 = '0;

    assign bus.iren      = iren;
    assign bus.iaddr     = iaddr;
    assign bus.dren      = dren;
    assign bus.dwen      = dwen;
    assign bus.daddr     = daddr;
    assign bus.dstore    = dstore;
    assign bus.ram_rdata = rdata;

    ram_arbiter #(.LATENCY(g + 1)) u_dut (
      .clk  (clk),
      .nrst (nrst),
      .bus  (bus.slave)
    );

    always @(posedge clk) begin
      if (|bus.ram_wen) begin
        wcnt <= wcnt + 1;
        if (bus.ram_addr == 32'h300) begin
          for (int b = 0; b < 4; b++) begin
            if (bus.ram_wen[b]) word300[8*b +: 8] <= bus.ram_wdata[8*b +: 8];
          end
        end
      end
    end
  end

  task automatic push_exp(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sbq.push_back(e);
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    vectors++;
    if (sbq.size() == 0) begin
      miscompares++;
      $display("FAIL sb_underflow observed %h expected <none>", obs);
    end else begin
      e = sbq.pop_front();
      assert (obs === e.val) else begin
        miscompares++;
        $error("FAIL %s observed %h expected %h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Holds reset for one cycle with requests up, checking the reset-time outputs of instance 0
  task automatic do_reset();
    nrst = 1'b0; iren = 1'b1; dren = 1'b1; dwen = 4'b0000;
    iaddr = 32'h0; daddr = 32'h0; dstore = 32'h0; rdata = 32'hFFFF_FFFF;
    push_exp("rst_iwait", 1); push_exp("rst_dwait", 1); push_exp("rst_ren", 0);
    push_exp("rst_wen", 0); push_exp("rst_iload", 0); push_exp("rst_dload", 0);
    smp();
    chk(32'(g_dut[0].bus.iwait)); chk(32'(g_dut[0].bus.dwait)); chk(32'(g_dut[0].bus.ram_ren));
    chk(32'(g_dut[0].bus.ram_wen)); chk(g_dut[0].bus.iload); chk(g_dut[0].bus.dload);
    nxt();
    iren = 1'b0; dren = 1'b0; nrst = 1'b1;
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    nrst = 1'b0; iren = 1'b0; dren = 1'b0; dwen = 4'b0000;
    iaddr = 32'h0; daddr = 32'h0; dstore = 32'h0; rdata = 32'h0;
    do_reset();

    // L=1 fetch only: zero stall every cycle
    iren = 1'b1; iaddr = 32'h100; rdata = 32'h13;
    for (int c = 0; c < 3; c++) begin
      push_exp("t1_iwait", 0); push_exp("t1_iload", 32'h13);
      push_exp("t1_ren", 1); push_exp("t1_addr", 32'h100);
      smp();
      chk(32'(g_dut[0].bus.iwait)); chk(g_dut[0].bus.iload);
      chk(32'(g_dut[0].bus.ram_ren)); chk(g_dut[0].bus.ram_addr);
      nxt();
    end
    do_reset();

    // L=1 fetch and load together: data first, fetch next, then flags cleared
    iren = 1'b1; iaddr = 32'h104; dren = 1'b1; daddr = 32'h200; rdata = 32'hD0D0;
    push_exp("t2c0_addr", 32'h200); push_exp("t2c0_dwait", 0);
    push_exp("t2c0_iwait", 1); push_exp("t2c0_dload", 32'hD0D0);
    smp();
    chk(g_dut[0].bus.ram_addr); chk(32'(g_dut[0].bus.dwait));
    chk(32'(g_dut[0].bus.iwait)); chk(g_dut[0].bus.dload);
    nxt();
    rdata = 32'h1111;
    push_exp("t2c1_addr", 32'h104); push_exp("t2c1_iwait", 0); push_exp("t2c1_dwait", 0);
    push_exp("t2c1_dload", 32'hD0D0); push_exp("t2c1_iload", 32'h1111);
    smp();
    chk(g_dut[0].bus.ram_addr); chk(32'(g_dut[0].bus.iwait)); chk(32'(g_dut[0].bus.dwait));
    chk(g_dut[0].bus.dload); chk(g_dut[0].bus.iload);
    nxt();
    rdata = 32'h2222;
    push_exp("t2c2_dload", 32'h2222); push_exp("t2c2_iwait", 1); push_exp("t2c2_addr", 32'h200);
    smp();
    chk(g_dut[0].bus.dload); chk(32'(g_dut[0].bus.iwait)); chk(g_dut[0].bus.ram_addr);
    nxt();
    do_reset();

    // L=3 fetch only: two stall cycles, strobe held for three
    iren = 1'b1; iaddr = 32'h180; rdata = 32'h33;
    for (int c = 0; c < 3; c++) begin
      push_exp("t3_iwait", (c < 2) ? 1 : 0); push_exp("t3_ren", 1);
      smp();
      chk(32'(g_dut[2].bus.iwait)); chk(32'(g_dut[2].bus.ram_ren));
      nxt();
    end
    iren = 1'b0;
    push_exp("t3_idle_ren", 0); push_exp("t3_idle_iwait", 0);
    smp();
    chk(32'(g_dut[2].bus.ram_ren)); chk(32'(g_dut[2].bus.iwait));
    nxt();
    do_reset();

    // L=2 byte store with a pending fetch: one write in the final store cycle
    w0 = g_dut[1].wcnt;
    dwen = 4'b0100; dstore = 32'h00AB_0000; daddr = 32'h300; iren = 1'b1; iaddr = 32'h400; rdata = 32'h0;
    push_exp("t4c0_wen", 0); push_exp("t4c0_dwait", 1); push_exp("t4c0_iwait", 1); push_exp("t4c0_addr", 32'h300);
    smp();
    chk(32'(g_dut[1].bus.ram_wen)); chk(32'(g_dut[1].bus.dwait)); chk(32'(g_dut[1].bus.iwait)); chk(g_dut[1].bus.ram_addr);
    nxt();
    push_exp("t4c1_wen", 4); push_exp("t4c1_dwait", 0); push_exp("t4c1_wdata", 32'h00AB_0000); push_exp("t4c1_iwait", 1);
    smp();
    chk(32'(g_dut[1].bus.ram_wen)); chk(32'(g_dut[1].bus.dwait)); chk(g_dut[1].bus.ram_wdata); chk(32'(g_dut[1].bus.iwait));
    nxt();
    push_exp("t4c2_wen", 0); push_exp("t4c2_addr", 32'h400); push_exp("t4c2_iwait", 1); push_exp("t4c2_dwait", 0);
    smp();
    chk(32'(g_dut[1].bus.ram_wen)); chk(g_dut[1].bus.ram_addr); chk(32'(g_dut[1].bus.iwait)); chk(32'(g_dut[1].bus.dwait));
    nxt();
    push_exp("t4c3_iwait", 0); push_exp("t4c3_addr", 32'h400); push_exp("t4c3_dwait", 0);
    smp();
    chk(32'(g_dut[1].bus.iwait)); chk(g_dut[1].bus.ram_addr); chk(32'(g_dut[1].bus.dwait));
    nxt();
    dwen = 4'b0000; iren = 1'b0;
    push_exp("t4c4_ren", 0); push_exp("t4c4_wen", 0);
    smp();
    chk(32'(g_dut[1].bus.ram_ren)); chk(32'(g_dut[1].bus.ram_wen));
    nxt();
    push_exp("t4_writes", 1); push_exp("t4_byte2", 32'hAB);
    chk(32'(g_dut[1].wcnt - w0)); chk(32'(g_dut[1].word300[23:16]));
    do_reset();

    // L=3 store abandoned by reset in its second cycle
    w0 = g_dut[2].wcnt;
    dwen = 4'b1111; daddr = 32'h500; dstore = 32'hCAFE_F00D;
    push_exp("t5c0_wen", 0); push_exp("t5c0_dwait", 1);
    smp();
    chk(32'(g_dut[2].bus.ram_wen)); chk(32'(g_dut[2].bus.dwait));
    nxt();
    nrst = 1'b0;
    push_exp("t5c1_wen", 0); push_exp("t5c1_ren", 0); push_exp("t5c1_dwait", 1);
    smp();
    chk(32'(g_dut[2].bus.ram_wen)); chk(32'(g_dut[2].bus.ram_ren)); chk(32'(g_dut[2].bus.dwait));
    nxt();
    nrst = 1'b1; dwen = 4'b0000;
    push_exp("t5c2_addr", 0); push_exp("t5c2_dwait", 0); push_exp("t5c2_wen", 0);
    smp();
    chk(g_dut[2].bus.ram_addr); chk(32'(g_dut[2].bus.dwait)); chk(32'(g_dut[2].bus.ram_wen));
    nxt();
    dren = 1'b1; daddr = 32'h504;
    for (int c = 0; c < 3; c++) begin
      push_exp("t5_rd_dwait", (c < 2) ? 1 : 0); push_exp("t5_rd_wen", 0);
      smp();
      chk(32'(g_dut[2].bus.dwait)); chk(32'(g_dut[2].bus.ram_wen));
      nxt();
    end
    dren = 1'b0;
    push_exp("t5_writes", 0);
    chk(32'(g_dut[2].wcnt - w0));
    do_reset();

    // L=2 done-hold: load result held while the fetch runs, no repeat data access
    dren = 1'b1; daddr = 32'h600; iren = 1'b1; iaddr = 32'h700; rdata = 32'hAAAA_0001;
    push_exp("t6c0_dwait", 1); push_exp("t6c0_iwait", 1); push_exp("t6c0_addr", 32'h600);
    smp();
    chk(32'(g_dut[1].bus.dwait)); chk(32'(g_dut[1].bus.iwait)); chk(g_dut[1].bus.ram_addr);
    nxt();
    push_exp("t6c1_dwait", 0); push_exp("t6c1_dload", 32'hAAAA_0001); push_exp("t6c1_addr", 32'h600);
    smp();
    chk(32'(g_dut[1].bus.dwait)); chk(g_dut[1].bus.dload); chk(g_dut[1].bus.ram_addr);
    nxt();
    rdata = 32'hBBBB_0002;
    push_exp("t6c2_dload", 32'hAAAA_0001); push_exp("t6c2_addr", 32'h700);
    push_exp("t6c2_iwait", 1); push_exp("t6c2_dwait", 0);
    smp();
    chk(g_dut[1].bus.dload); chk(g_dut[1].bus.ram_addr); chk(32'(g_dut[1].bus.iwait)); chk(32'(g_dut[1].bus.dwait));
    nxt();
    rdata = 32'hBBBB_0003;
    push_exp("t6c3_iwait", 0); push_exp("t6c3_iload", 32'hBBBB_0003);
    push_exp("t6c3_dload", 32'hAAAA_0001); push_exp("t6c3_addr", 32'h700);
    smp();
    chk(32'(g_dut[1].bus.iwait)); chk(g_dut[1].bus.iload); chk(g_dut[1].bus.dload); chk(g_dut[1].bus.ram_addr);
    nxt();
    iren = 1'b0; dren = 1'b0;
    push_exp("t6c4_ren", 0);
    smp();
    chk(32'(g_dut[1].bus.ram_ren));
    nxt();

    vectors++;
    assert (sbq.size() == 0) else begin
      miscompares++;
      $error("FAIL sb_leftover observed %0d expected 0", sbq.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
